// File: rtl/arith_pkg.sv
// Shared types and helpers for the sequential multi-word adder.
package arith_pkg;

    // Control states of the slice sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the slice index counter; never narrower than one bit so WORDS=1 still elaborates.
    function automatic int unsigned idx_width(input int unsigned words);
        int unsigned w;
        w = $clog2(words);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational N-bit ripple-carry adder slice.
module adder_slice #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    // Bit-serial ripple: each full adder feeds its carry to the next bit.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[N];
    end

endmodule

// File: rtl/multiword_adder_seq.sv
// Sequential wide adder: one N-bit slice reused over WORDS cycles, carry registered between slices.
module multiword_adder_seq
    import arith_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*WORDS-1:0] a_in,
    input  logic [N*WORDS-1:0] b_in,
    input  logic               cin_in,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               overflow
);

    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IdxW = idx_width(WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [N-1:0]      slice_a;
    logic [N-1:0]      slice_b;
    logic [N-1:0]      slice_s;
    logic              slice_cout;
    logic [WORDS-1:0]  slice_we;
    logic              accept;
    logic              last_slice;

    assign accept     = (state_q == IDLE) && start;
    assign last_slice = (state_q == RUN) && (idx_q == LastIdx);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LastIdx) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Select the operand words for the current slice index.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IdxW'(w)) begin
                slice_a = a_q[w*N +: N];
                slice_b = b_q[w*N +: N];
            end
        end
    end

    adder_slice #(
        .N (N)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Per-slice write enables for the sum register.
    always_comb begin
        slice_we = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            slice_we[w] = (state_q == RUN) && (idx_q == IdxW'(w));
        end
    end

    // Datapath next state: operand capture, carry chaining, sum collection, final flags.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (accept) begin
            a_d     = a_in;
            b_d     = b_in;
            idx_d   = '0;
            carry_d = cin_in;
        end

        if (state_q == RUN) begin
            carry_d = slice_cout;
            idx_d   = last_slice ? '0 : idx_q + 1'b1;
        end

        for (int unsigned w = 0; w < WORDS; w++) begin
            if (slice_we[w]) begin
                sum_d[w*N +: N] = slice_s;
            end
        end

        // The top slice carries bit W-1, so its carry-in is recoverable from the sum bit.
        if (last_slice) begin
            cout_d = slice_cout;
            ovf_d  = slice_cout ^ (a_q[W-1] ^ b_q[W-1] ^ slice_s[N-1]);
        end
    end

    // Datapath registers; reset discards any partially accumulated result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq with N=4, WORDS=4 and a result scoreboard.
module tb_multiword_adder_seq;

    localparam int unsigned N     = 4;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    multiword_adder_seq #(
        .N     (N),
        .WORDS (WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t       m;
        logic [W:0] t;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        m.sum  = t[W-1:0];
        m.cout = t[W];
        m.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return m;
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive operands with start high for one edge (the accept edge) and record the expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        a_in   = a;
        b_in   = b;
        cin_in = c;
        start  = 1'b1;
        sb.push_back(model(a, b, c));
        step();
        start  = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts edges after the accept edge.
    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        seen = done;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        #12;
        n_checks++;
        if ({ready, busy, done, sum, cout, overflow} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_hold: got rdy=%b busy=%b done=%b sum=%h cout=%b ovf=%b want 1 0 0 0000 0 0",
                     ready, busy, done, sum, cout, overflow);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({ready, busy, done, sum} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_release: got rdy=%b busy=%b done=%b sum=%h want 1 0 0 0000",
                     ready, busy, done, sum);
        end
    endtask

    task automatic test_carry_chain();
        exp_t e;
        int   lat;
        bit   seen;
        issue(16'hFFFF, 16'h0001, 1'b0);
        // After each slice edge the registered carry must still be 1 and the written nibble 0.
        for (int i = 0; i < int'(WORDS); i++) begin
            n_checks++;
            if (!busy || ready) begin
                n_errors++;
                $display("FAIL carry_busy[%0d]: got busy=%b ready=%b want 1 0", i, busy, ready);
            end
            step();
            n_checks++;
            if (dut.carry_q !== 1'b1 || sum[i*N +: N] !== 4'h0) begin
                n_errors++;
                $display("FAIL carry_prop[%0d]: got carry=%b nibble=%h want 1 0",
                         i, dut.carry_q, sum[i*N +: N]);
            end
        end
        // Slice 3 written on edge k+4; done must be visible right after it.
        wait_done(lat, seen);
        n_checks++;
        if (!seen || lat != 0) begin
            n_errors++;
            $display("FAIL carry_latency: got seen=%b extra_edges=%0d want seen=1 extra_edges=0", seen, lat);
        end
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                n_errors++;
                $display("FAIL carry_result: got %h/%b/%b want %h/%b/%b", sum, cout, overflow, e.sum, e.cout, e.ovf);
            end
        end
        step();
    endtask

    task automatic test_overflow();
        logic [W-1:0] av[2];
        logic [W-1:0] bv[2];
        exp_t         e;
        int           lat;
        bit           seen;
        av[0] = 16'h7FFF; bv[0] = 16'h0001;
        av[1] = 16'h8000; bv[1] = 16'h8000;
        for (int i = 0; i < 2; i++) begin
            issue(av[i], bv[i], 1'b0);
            wait_done(lat, seen);
            n_checks++;
            if (!seen || lat != int'(WORDS)) begin
                n_errors++;
                $display("FAIL ovf_latency[%0d]: got seen=%b lat=%0d want 1 %0d", i, seen, lat, WORDS);
            end
            if (seen && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                    n_errors++;
                    $display("FAIL ovf_result[%0d]: got %h/%b/%b want %h/%b/%b",
                             i, sum, cout, overflow, e.sum, e.cout, e.ovf);
                end
            end
            step();
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int   lat;
        bit   seen;
        issue(16'h1234, 16'h4321, 1'b1);
        wait_done(lat, seen);
        e = model(16'h1234, 16'h4321, 1'b1);
        if (sb.size() > 0) e = sb.pop_front();
        n_checks++;
        if (!seen || {sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
            n_errors++;
            $display("FAIL hold_result: got seen=%b %h/%b/%b want 1 %h/%b/%b",
                     seen, sum, cout, overflow, e.sum, e.cout, e.ovf);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({sum, cout, overflow, done} !== {e.sum, e.cout, e.ovf, 1'b0}) begin
                n_errors++;
                $display("FAIL hold_idle[%0d]: got %h/%b/%b done=%b want %h/%b/%b done=0",
                         i, sum, cout, overflow, done, e.sum, e.cout, e.ovf);
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   n;
        issue(16'h00F0, 16'h0010, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            n_checks++;
            if (ready) begin
                n_errors++;
                $display("FAIL ign_ready[%0d]: got ready=%b want 0", n, ready);
            end
            // Disturbing request in the middle of RUN.
            if (n == 1) begin
                a_in  = 16'hAAAA;
                b_in  = 16'h5555;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        // Disturbing request during the DONE cycle.
        a_in  = 16'hAAAA;
        b_in  = 16'h5555;
        start = 1'b1;
        e     = model(16'h00F0, 16'h0010, 1'b0);
        if (sb.size() > 0) e = sb.pop_front();
        n_checks++;
        if (!done || ready || {sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
            n_errors++;
            $display("FAIL ign_result: got done=%b ready=%b %h/%b/%b want 1 0 %h/%b/%b",
                     done, ready, sum, cout, overflow, e.sum, e.cout, e.ovf);
        end
        step();
        start = 1'b0;
        step();
        n_checks++;
        if (!ready || busy || sum !== e.sum) begin
            n_errors++;
            $display("FAIL ign_no_restart: got ready=%b busy=%b sum=%h want 1 0 %h", ready, busy, sum, e.sum);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   lat;
        bit   seen;
        bit   saw_done;
        issue(16'h1357, 16'h2468, 1'b1);
        step();
        step();
        step();
        // Slices 0..2 written; assert reset between edges.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ready, busy, done, sum, cout, overflow} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL arst_immediate: got rdy=%b busy=%b done=%b sum=%h cout=%b ovf=%b want 1 0 0 0000 0 0",
                     ready, busy, done, sum, cout, overflow);
        end
        void'(sb.pop_back());
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done || sum !== '0) begin
            n_errors++;
            $display("FAIL arst_no_done: got saw_done=%b sum=%h want 0 0000", saw_done, sum);
        end
        issue(16'h0FFF, 16'h0001, 1'b0);
        wait_done(lat, seen);
        e = model(16'h0FFF, 16'h0001, 1'b0);
        if (sb.size() > 0) e = sb.pop_front();
        n_checks++;
        if (!seen || lat != int'(WORDS) || {sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
            n_errors++;
            $display("FAIL arst_after: got seen=%b lat=%0d %h/%b/%b want 1 %0d %h/%b/%b",
                     seen, lat, sum, cout, overflow, WORDS, e.sum, e.cout, e.ovf);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        int           accepted;
        int           n_done;
        int           last_acc;
        int           cyc;
        bit           gap_err;
        accepted = 0;
        n_done   = 0;
        last_acc = -1;
        cyc      = 0;
        gap_err  = 1'b0;
        while (n_done < 200 && cyc < 200 * 6 + 50) begin
            if (done) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL b2b_extra_done: got done at cycle %0d want no pending op", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                        n_errors++;
                        $display("FAIL b2b_result[%0d]: got %h/%b/%b want %h/%b/%b",
                                 n_done, sum, cout, overflow, e.sum, e.cout, e.ovf);
                    end
                end
                n_done++;
            end
            if (ready && accepted < 200) begin
                a = W'($urandom);
                b = W'($urandom);
                c = 1'($urandom_range(0, 1));
                a_in   = a;
                b_in   = b;
                cin_in = c;
                start  = 1'b1;
                sb.push_back(model(a, b, c));
                if (last_acc >= 0 && cyc - last_acc != int'(WORDS) + 2) gap_err = 1'b1;
                last_acc = cyc;
                accepted++;
            end else if (accepted >= 200) begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        n_checks++;
        if (n_done != 200 || accepted != 200 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_count: got done=%0d accepted=%0d pending=%0d want 200 200 0",
                     n_done, accepted, sb.size());
        end
        n_checks++;
        if (gap_err) begin
            n_errors++;
            $display("FAIL b2b_spacing: got irregular start spacing want every %0d edges", WORDS + 2);
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_overflow();
        test_hold();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
